diag_func_master: RTL and testbench

Front-end side of the EBUS diagnostic-function protocol. Accepts one diagnostic function request at a time from the console/front-end logic and sequences it onto the EBUS diagnostic lines. It drives the 7-bit function select, the write data and the diagnostic strobe, and for read functions samples the 36-bit EBUS data returned by the board that decodes the select. It is the initiator that CON and the other EBOX boards answer for DIAG_CTL functions (clear/set run, continue, IR and DRAM strobes) and for diagnostic reads.

---
 rtl/diag_func_master_if.sv | 31 +++
 rtl/diag_func_master.sv | 166 ++++++++++++++++
 tb/tb_diag_func_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/diag_func_master_if.sv
// EBUS diagnostic-function bundle: request/response handshake plus the diagnostic bus lines.
// The master modport is the initiator's view; the slave modport is the console/EBUS side.
interface diag_func_master_if;
  logic        reqValid;
  logic        reqReady;
  logic [0:6]  reqFunc;
  logic [0:35] reqData;
  logic        rspValid;
  logic        rspReady;
  logic [0:35] rspData;
  logic        rspParErr;
  logic [0:6]  ebusDs;
  logic        ebusDiagStrobe;
  logic [0:35] ebusData;
  logic        ebusDataDrive;
  logic        ebusParityOut;
  logic [0:35] ebusDataIn;
  logic        ebusParityIn;

  modport master (
    input  reqValid, reqFunc, reqData, rspReady, ebusDataIn, ebusParityIn,
    output reqReady, rspValid, rspData, rspParErr,
    output ebusDs, ebusDiagStrobe, ebusData, ebusDataDrive, ebusParityOut
  );

  modport slave (
    output reqValid, reqFunc, reqData, rspReady, ebusDataIn, ebusParityIn,
    input  reqReady, rspValid, rspData, rspParErr,
    input  ebusDs, ebusDiagStrobe, ebusData, ebusDataDrive, ebusParityOut
  );
endinterface

// File: rtl/diag_func_master.sv
// EBUS diagnostic-function initiator: runs one request through setup/strobe/hold and returns
// captured read data. Define DIAG_PARITY_EN to enable bus parity generation and checking.
module diag_func_master #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned SAMPLE_CYCLE  = 3,
  parameter int unsigned HOLD_CYCLES   = 2
) (
  input logic                clk,
  input logic                resetN,
  diag_func_master_if.master bus
);

  localparam int unsigned MaxSs     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES
                                                                     : STROBE_CYCLES;
  localparam int unsigned MaxCycles = (MaxSs > HOLD_CYCLES) ? MaxSs : HOLD_CYCLES;
  // Counter loads N-1 and expires at zero, so clog2(N) bits cover the longest phase.
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] SampleCnt  = CntW'(STROBE_CYCLES - SAMPLE_CYCLE);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [0:6]        func_q, func_d;
  logic [0:35]       wdata_q, wdata_d;
  logic [0:35]       rsp_data_q, rsp_data_d;
  logic              rsp_par_err_q, rsp_par_err_d;
  logic [0:6]        ds_q, ds_d;
  logic              strobe_q, strobe_d;
  logic [0:35]       ebus_data_q, ebus_data_d;
  logic              drive_q, drive_d;
  logic              parity_q, parity_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy;
  logic              sample_par_err;

`ifdef DIAG_PARITY_EN
  assign sample_par_err = bus.ebusParityIn != ~^bus.ebusDataIn;
`else
  logic unused_parity_in;
  assign unused_parity_in = bus.ebusParityIn;
  assign sample_par_err   = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    func_d        = func_q;
    wdata_d       = wdata_q;
    rsp_data_d    = rsp_data_q;
    rsp_par_err_d = rsp_par_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.reqValid) begin
          func_d  = bus.reqFunc;
          wdata_d = bus.reqData;
          cnt_d   = SetupLoad;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          cnt_d   = StrobeLoad;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        // func bit 0 is the read flag (octal 100-177)
        if (func_q[0] && (cnt_q == SampleCnt)) begin
          rsp_data_d    = bus.ebusDataIn;
          rsp_par_err_d = sample_par_err;
        end
        if (cnt_q == '0) begin
          if (HOLD_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            cnt_d   = HoldLoad;
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (bus.rspReady) begin
          state_d       = StIdle;
          rsp_data_d    = '0;
          rsp_par_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so every bus line comes straight from a flop.
    busy        = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    ds_d        = busy ? func_d : '0;
    drive_d     = busy && !func_d[0];
    ebus_data_d = drive_d ? wdata_d : '0;
    strobe_d    = (state_d == StStrobe);
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
`ifdef DIAG_PARITY_EN
    parity_d    = drive_d && (~^wdata_d);
`else
    parity_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      func_q        <= '0;
      wdata_q       <= '0;
      rsp_data_q    <= '0;
      rsp_par_err_q <= 1'b0;
      ds_q          <= '0;
      strobe_q      <= 1'b0;
      ebus_data_q   <= '0;
      drive_q       <= 1'b0;
      parity_q      <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      func_q        <= func_d;
      wdata_q       <= wdata_d;
      rsp_data_q    <= rsp_data_d;
      rsp_par_err_q <= rsp_par_err_d;
      ds_q          <= ds_d;
      strobe_q      <= strobe_d;
      ebus_data_q   <= ebus_data_d;
      drive_q       <= drive_d;
      parity_q      <= parity_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign bus.reqReady       = req_ready_q;
  assign bus.rspValid       = rsp_valid_q;
  assign bus.rspData        = rsp_data_q;
  assign bus.rspParErr      = rsp_par_err_q;
  assign bus.ebusDs         = ds_q;
  assign bus.ebusDiagStrobe = strobe_q;
  assign bus.ebusData       = ebus_data_q;
  assign bus.ebusDataDrive  = drive_q;
  assign bus.ebusParityOut  = parity_q;

endmodule

// File: tb/tb_diag_func_master.sv
// Bench for diag_func_master: default-parameter instance plus a short-strobe/no-hold instance,
// with a response scoreboard fed by the stimulus and drained by an independent monitor.
module tb_diag_func_master;

  localparam int unsigned S  = 2, ST  = 4, H  = 2, SM  = 3;
  localparam int unsigned ES = 2, EST = 1, EH = 0, ESM = 1;
  localparam logic [0:35] Junk = 36'o525252525252;

  typedef struct {
    logic [0:35] data;
    logic        perr;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  diag_func_master_if bus_a ();
  diag_func_master_if bus_b ();

  diag_func_master #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(ST),
    .SAMPLE_CYCLE (SM),
    .HOLD_CYCLES  (H)
  ) u_dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus_a)
  );

  diag_func_master #(
    .SETUP_CYCLES (ES),
    .STROBE_CYCLES(EST),
    .SAMPLE_CYCLE (ESM),
    .HOLD_CYCLES  (EH)
  ) u_edge (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0o required=%0o", name, act, exp);
    end
  endtask

  task automatic set_req(input bit e, input logic v, input logic [0:6] f, input logic [0:35] d);
    if (e) begin
      bus_b.reqValid = v; bus_b.reqFunc = f; bus_b.reqData = d;
    end else begin
      bus_a.reqValid = v; bus_a.reqFunc = f; bus_a.reqData = d;
    end
  endtask

  task automatic set_rdy(input bit e, input logic v);
    if (e) bus_b.rspReady = v;
    else   bus_a.rspReady = v;
  endtask

  task automatic set_din(input logic [0:35] d, input logic p);
    bus_a.ebusDataIn = d; bus_b.ebusDataIn = d;
    bus_a.ebusParityIn = p; bus_b.ebusParityIn = p;
  endtask

  // Returns #1 after the accepting edge.
  task automatic wait_accept(input bit e, input int exp_wait, output bit ok, output int acc);
    bit rdy;
    int n;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = e ? bus_b.reqReady : bus_a.reqReady;
      @(posedge clk);
      n++;
    end
    #1;
    acc = cyc;
    ok  = rdy;
    if (!rdy) check("accept_timeout", 0, 1);
    else      check($sformatf("accept_wait_e%0d", e), n, exp_wait);
  endtask

  task automatic run_txn(input bit e, input logic [0:6] func, input logic [0:35] wdata,
                         input logic [0:35] rdata, input bit bad_par, input int exp_wait,
                         input int hold_rdy, input bit queue_next, input logic [0:6] nfunc,
                         input logic [0:35] ndata);
    int s, st, sm, lat, acc;
    bit ok, rd;
    exp_t x;
    logic exp_par;
    s   = e ? ES : S;
    st  = e ? EST : ST;
    sm  = e ? ESM : SM;
    lat = s + st + (e ? EH : H);
    rd  = func[0];
    set_req(e, 1'b1, func, wdata);
    wait_accept(e, exp_wait, ok, acc);
    set_req(e, 1'b0, func, wdata);
    if (ok) begin
      set_rdy(e, hold_rdy == 0);
      x.data = rd ? rdata : '0;
`ifdef DIAG_PARITY_EN
      x.perr  = rd && bad_par;
      exp_par = !rd && (~^wdata);
`else
      x.perr  = 1'b0;
      exp_par = 1'b0;
`endif
      x.acc = acc;
      x.lat = lat;
      if (e) q_b.push_back(x);
      else   q_a.push_back(x);
      for (int t = 0; t < lat; t++) begin
        if (rd && t == s + sm - 1) set_din(rdata, bad_par ? ^rdata : ~^rdata);
        else                       set_din(Junk, ~^Junk);
        @(negedge clk);
        check($sformatf("e%0d_ds_t%0d", e, t), e ? bus_b.ebusDs : bus_a.ebusDs, func);
        check($sformatf("e%0d_strobe_t%0d", e, t),
              e ? bus_b.ebusDiagStrobe : bus_a.ebusDiagStrobe, (t >= s) && (t < s + st));
        check($sformatf("e%0d_drive_t%0d", e, t),
              e ? bus_b.ebusDataDrive : bus_a.ebusDataDrive, !rd);
        check($sformatf("e%0d_data_t%0d", e, t),
              e ? bus_b.ebusData : bus_a.ebusData, rd ? 36'o0 : wdata);
        check($sformatf("e%0d_parout_t%0d", e, t),
              e ? bus_b.ebusParityOut : bus_a.ebusParityOut, exp_par);
        check($sformatf("e%0d_reqready_t%0d", e, t), e ? bus_b.reqReady : bus_a.reqReady, 0);
        check($sformatf("e%0d_rspvalid_t%0d", e, t), e ? bus_b.rspValid : bus_a.rspValid, 0);
        @(posedge clk);
        #1;
      end
      set_din(Junk, ~^Junk);
      if (hold_rdy > 0) begin
        if (queue_next) set_req(e, 1'b1, nfunc, ndata);
        for (int i = 0; i < hold_rdy; i++) begin
          @(negedge clk);
          check($sformatf("e%0d_rspvalid_held_%0d", e, i),
                e ? bus_b.rspValid : bus_a.rspValid, 1);
          @(posedge clk);
          #1;
        end
        set_rdy(e, 1'b1);
      end
    end
  endtask

  // Scoreboard monitor: pops on each new response, then rechecks every cycle it stays valid.
  initial begin : monitor
    exp_t        cur [2];
    bit          seen [2];
    logic        v, rr, pe;
    logic [0:35] d;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        v  = (i == 1) ? bus_b.rspValid  : bus_a.rspValid;
        rr = (i == 1) ? bus_b.reqReady  : bus_a.reqReady;
        d  = (i == 1) ? bus_b.rspData   : bus_a.rspData;
        pe = (i == 1) ? bus_b.rspParErr : bus_a.rspParErr;
        if (!resetN || !v) begin
          seen[i] = 1'b0;
        end else begin
          if (!seen[i]) begin
            if ((i == 1 ? q_b.size() : q_a.size()) == 0) begin
              check($sformatf("rsp%0d_unexpected", i), 1, 0);
            end else begin
              if (i == 1) cur[i] = q_b.pop_front();
              else        cur[i] = q_a.pop_front();
              seen[i] = 1'b1;
              check($sformatf("rsp%0d_latency", i), cyc - cur[i].acc, cur[i].lat);
            end
          end
          if (seen[i]) begin
            check($sformatf("rsp%0d_data", i), d, cur[i].data);
            check($sformatf("rsp%0d_parerr", i), pe, cur[i].perr);
          end
          check($sformatf("rsp%0d_reqready_busy", i), rr, 0);
        end
      end
    end
  end

  initial begin : stim
    bit ok;
    int acc;
    resetN = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0);
    set_rdy(1'b0, 1'b1);
    set_rdy(1'b1, 1'b1);
    set_din(Junk, ~^Junk);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    @(negedge clk);
    check("rst_reqready", bus_a.reqReady, 1);
    check("rst_rspvalid", bus_a.rspValid, 0);
    check("rst_rspdata", bus_a.rspData, 0);
    check("rst_parerr", bus_a.rspParErr, 0);
    check("rst_ds", bus_a.ebusDs, 0);
    check("rst_strobe", bus_a.ebusDiagStrobe, 0);
    check("rst_data", bus_a.ebusData, 0);
    check("rst_drive", bus_a.ebusDataDrive, 0);
    check("rst_parout", bus_a.ebusParityOut, 0);
    check("rst_edge_reqready", bus_b.reqReady, 1);
    @(posedge clk);
    #1;

    // CONTINUE control function, then a clean read, a write, and a bad-parity read with
    // backpressure while the next write is already queued.
    run_txn(1'b0, 7'o012, 36'o0, 36'o0, 1'b0, 1, 0, 1'b0, '0, '0);
    run_txn(1'b0, 7'o130, 36'o0, 36'o123456654321, 1'b0, 2, 0, 1'b0, '0, '0);
    run_txn(1'b0, 7'o044, 36'o777000000777, 36'o0, 1'b0, 2, 0, 1'b0, '0, '0);
    run_txn(1'b0, 7'o130, 36'o0, 36'o000111222333, 1'b1, 2, 5, 1'b1, 7'o044, 36'o123123123123);
    run_txn(1'b0, 7'o044, 36'o123123123123, 36'o0, 1'b0, 2, 0, 1'b0, '0, '0);

    // Reset asserted between clock edges during strobe cycle 2 of a write.
    set_req(1'b0, 1'b1, 7'o044, 36'o707070070707);
    wait_accept(1'b0, 2, ok, acc);
    set_req(1'b0, 1'b0, '0, '0);
    if (ok) begin
      repeat (S + 1) begin
        @(posedge clk);
        #1;
      end
      #2;
      check("pre_reset_strobe", bus_a.ebusDiagStrobe, 1);
      resetN = 1'b0;
      #1;
      check("async_rst_strobe", bus_a.ebusDiagStrobe, 0);
      check("async_rst_ds", bus_a.ebusDs, 0);
      check("async_rst_drive", bus_a.ebusDataDrive, 0);
      check("async_rst_data", bus_a.ebusData, 0);
      check("async_rst_reqready", bus_a.reqReady, 1);
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check("post_rst_no_rsp", bus_a.rspValid, 0);
        check("post_rst_reqready", bus_a.reqReady, 1);
      end
      @(posedge clk);
      #1;
    end

    // Single-cycle strobe, no hold: a read then a back-to-back write.
    run_txn(1'b1, 7'o101, 36'o0, 36'o765432101234, 1'b0, 1, 0, 1'b0, '0, '0);
    run_txn(1'b1, 7'o005, 36'o000000000001, 36'o0, 1'b0, 2, 0, 1'b0, '0, '0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", q_a.size() + q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
